// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing constants and pointer helpers for the 4-entry FIFO controller.
// Revision 1.0 - initial release
`default_nettype none

package fifo_pkg;

  localparam int DEPTH              = 4;
  localparam int PTR_W              = 3;
  localparam int IDX_W              = 2;
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef logic [PTR_W-1:0] ptr_t;

  // Full when the wrap bits differ but the slot indices coincide.
  function automatic logic ptr_full(input ptr_t wr, input ptr_t rd);
    return (wr[PTR_W-1] != rd[PTR_W-1]) && (wr[IDX_W-1:0] == rd[IDX_W-1:0]);
  endfunction

  function automatic logic ptr_empty(input ptr_t wr, input ptr_t rd);
    return wr == rd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_ctrl_ptr_cnt.sv
// ptr_cnt: free-running wrap-around pointer with increment enable and async active-low clear.
// Revision 1.0 - initial release
`default_nettype none

module ptr_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: 4-entry show-ahead FIFO with flop storage, extra-bit pointers and error pulse.
// Revision 1.0 - initial release
`default_nettype none

module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W-1:0]      wr_ptr_curr,
  output logic [PTR_W-1:0]      rd_ptr_curr,
  output logic [PTR_W-1:0]      count,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push_ok;
  logic                  pop_ok;
  logic                  err_q;
  logic                  err_d;

  // Push and pop are judged independently against the flags of the current cycle.
  assign push_ok = valid & ~full;
  assign pop_ok  = rd_en & ~empty;

  ptr_cnt #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (push_ok),
    .ptr_o (wr_ptr_curr)
  );

  ptr_cnt #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pop_ok),
    .ptr_o (rd_ptr_curr)
  );

  // Storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_curr[IDX_W-1:0]] <= data_in;
  end

  assign data_out = mem_q[rd_ptr_curr[IDX_W-1:0]];
  assign empty    = ptr_empty(wr_ptr_curr, rd_ptr_curr);
  assign full     = ptr_full(wr_ptr_curr, rd_ptr_curr);
  assign count    = wr_ptr_curr - rd_ptr_curr;

  always_comb begin
    err_d = (valid & full) | (rd_en & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl; a reference queue tracks accepted pushes.
// Revision 1.0 - initial release
`default_nettype none

module tb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [15:0] data_in;
  logic        rd_en;
  logic [15:0] data_out;
  logic        full;
  logic        empty;
  logic [2:0]  wr_ptr_curr;
  logic [2:0]  rd_ptr_curr;
  logic [2:0]  count;
  logic        err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [2:0]  m_wr;
  logic [2:0]  m_rd;
  logic        m_err;
  logic [15:0] exp_q [$];

  fifo_ctrl #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .wr_ptr_curr (wr_ptr_curr),
    .rd_ptr_curr (rd_ptr_curr),
    .count       (count),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] m_cnt();
    return m_wr - m_rd;
  endfunction

  // Drives one clock of stimulus and advances the reference model; leaves time at edge+1.
  task automatic drive(input logic v, input logic [15:0] d, input logic r);
    logic push_ok, pop_ok;
    valid = v; data_in = d; rd_en = r;
    push_ok = v && (m_cnt() != 3'd4);
    pop_ok  = r && (m_cnt() != 3'd0);
    @(posedge clk);
    if (pop_ok) void'(exp_q.pop_front());
    if (push_ok) begin exp_q.push_back(d); m_wr = m_wr + 3'd1; end
    if (pop_ok) m_rd = m_rd + 3'd1;
    m_err = (v && !push_ok) || (r && !pop_ok);
    #1;
    valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; valid = 1'b0; rd_en = 1'b0; data_in = '0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got=%b exp=0", full); end
    n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", err); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (wr_ptr_curr !== 3'd0 || rd_ptr_curr !== 3'd0) begin
      n_errors++; $display("FAIL reset_ptrs got wr=%0d rd=%0d exp 0 0", wr_ptr_curr, rd_ptr_curr); end
    @(negedge clk);
    rst_n = 1'b1;
    m_wr = '0; m_rd = '0; m_err = 1'b0; exp_q.delete();
  endtask

  task automatic test_fill();
    logic [15:0] vals [4];
    vals = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
    foreach (vals[i]) drive(1'b1, vals[i], 1'b0);
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL fill_full got=%b exp=1", full); end
    n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL fill_count got=%0d exp=4", count); end
    n_checks++; if (wr_ptr_curr !== 3'd4) begin n_errors++; $display("FAIL fill_wrptr got=%0d exp=4", wr_ptr_curr); end
    n_checks++; if (data_out !== 16'h00A1) begin n_errors++; $display("FAIL fill_head got=%h exp=00a1", data_out); end
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL fill_err got=%b exp=0", err); end
  endtask

  task automatic test_overflow_drain();
    drive(1'b1, 16'h00EE, 1'b0);
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL ovf_err got=%b exp=1", err); end
    n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL ovf_count got=%0d exp=4", count); end
    n_checks++; if (data_out !== exp_q[0]) begin n_errors++; $display("FAIL ovf_head got=%h exp=%h", data_out, exp_q[0]); end
    drive(1'b0, 16'h0000, 1'b0);
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL ovf_err_pulse got=%b exp=0", err); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (data_out !== exp_q[0]) begin
        n_errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, exp_q[0]); end
      drive(1'b0, 16'h0000, 1'b1);
    end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow();
    logic [2:0] rd0;
    rd0 = m_rd;
    drive(1'b0, 16'h0000, 1'b1);
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL udf_err got=%b exp=1", err); end
    n_checks++; if (rd_ptr_curr !== rd0) begin n_errors++; $display("FAIL udf_rdptr got=%0d exp=%0d", rd_ptr_curr, rd0); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL udf_empty got=%b exp=1", empty); end
    drive(1'b0, 16'h0000, 1'b0);
    n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL udf_err_pulse got=%b exp=0", err); end
  endtask

  task automatic test_wrap();
    bit wrapped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_wr == 3'd7) wrapped = 1'b1;
      drive(1'b1, 16'h1000 + 16'(i), 1'b0);
      n_checks++; if (empty !== 1'b0 || full !== 1'b0) begin
        n_errors++; $display("FAIL wrap_flags[%0d] got empty=%b full=%b exp 0 0", i, empty, full); end
      n_checks++; if (data_out !== exp_q[0]) begin
        n_errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, data_out, exp_q[0]); end
      drive(1'b0, 16'h0000, 1'b1);
      n_checks++; if (empty !== 1'b1 || rd_ptr_curr !== m_rd || wr_ptr_curr !== m_wr) begin
        n_errors++; $display("FAIL wrap_ptrs[%0d] got empty=%b wr=%0d rd=%0d exp 1 %0d %0d",
                             i, empty, wr_ptr_curr, rd_ptr_curr, m_wr, m_rd); end
    end
    n_checks++; if (!wrapped || wr_ptr_curr !== 3'd6) begin
      n_errors++; $display("FAIL wrap_final got wr=%0d wrapped=%b exp wr=6 wrapped=1", wr_ptr_curr, wrapped); end
  endtask

  task automatic test_simultaneous();
    logic [2:0] w0, r0;
    drive(1'b1, 16'h0021, 1'b0);
    drive(1'b1, 16'h0022, 1'b0);
    w0 = m_wr; r0 = m_rd;
    drive(1'b1, 16'h0023, 1'b1);
    n_checks++; if (count !== 3'd2 || err !== 1'b0) begin
      n_errors++; $display("FAIL sim_mid got count=%0d err=%b exp 2 0", count, err); end
    n_checks++; if (wr_ptr_curr !== w0 + 3'd1 || rd_ptr_curr !== r0 + 3'd1) begin
      n_errors++; $display("FAIL sim_mid_ptrs got wr=%0d rd=%0d exp %0d %0d", wr_ptr_curr, rd_ptr_curr, w0 + 3'd1, r0 + 3'd1); end
    drive(1'b1, 16'h0024, 1'b0);
    drive(1'b1, 16'h0025, 1'b0);
    n_checks++; if (full !== 1'b1 || data_out !== exp_q[0]) begin
      n_errors++; $display("FAIL sim_full_pre got full=%b head=%h exp 1 %h", full, data_out, exp_q[0]); end
    drive(1'b1, 16'h0026, 1'b1);
    n_checks++; if (count !== 3'd3 || err !== 1'b1) begin
      n_errors++; $display("FAIL sim_full got count=%0d err=%b exp 3 1", count, err); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (data_out !== exp_q[0]) begin
        n_errors++; $display("FAIL sim_drain[%0d] got=%h exp=%h", i, data_out, exp_q[0]); end
      drive(1'b0, 16'h0000, 1'b1);
    end
    drive(1'b1, 16'h0027, 1'b1);
    n_checks++; if (count !== 3'd1 || err !== 1'b1 || data_out !== 16'h0027) begin
      n_errors++; $display("FAIL sim_empty got count=%0d err=%b head=%h exp 1 1 0027", count, err, data_out); end
    n_checks++; if (m_cnt() !== count) begin
      n_errors++; $display("FAIL sim_model_count got=%0d exp=%0d", count, m_cnt()); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 16'h0031, 1'b0);
    drive(1'b1, 16'h0032, 1'b0);
    n_checks++; if (count !== 3'd3) begin n_errors++; $display("FAIL rmid_pre_count got=%0d exp=3", count); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1 || count !== 3'd0 || full !== 1'b0) begin
      n_errors++; $display("FAIL rmid_async got empty=%b count=%0d full=%b exp 1 0 0", empty, count, full); end
    n_checks++; if (wr_ptr_curr !== 3'd0 || rd_ptr_curr !== 3'd0 || err !== 1'b0) begin
      n_errors++; $display("FAIL rmid_ptrs got wr=%0d rd=%0d err=%b exp 0 0 0", wr_ptr_curr, rd_ptr_curr, err); end
    @(negedge clk);
    rst_n = 1'b1;
    m_wr = '0; m_rd = '0; m_err = 1'b0; exp_q.delete();
    drive(1'b1, 16'h005A, 1'b0);
    n_checks++; if (wr_ptr_curr !== 3'd1 || count !== 3'd1 || data_out !== 16'h005A) begin
      n_errors++; $display("FAIL rmid_push got wr=%0d count=%0d head=%h exp 1 1 005a", wr_ptr_curr, count, data_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout reached exp=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
